// File: rtl/br_redirect_ctrl.sv
// Control-flow redirect sequencer: arbitrates WB flushes and EX taken branches
// into one held redirect request to fetch, drives wrong-path kills, counts branches.
module br_redirect_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_is_bj,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             wb_flush,
  input  logic [31:0]      wb_target,
  input  logic             if_ready,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  output logic             flush_fd,
  output logic             ex_kill,
  output logic [CNT_W-1:0] cnt_br,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_stall
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] cnt_br_q, cnt_br_d;
  logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;

  logic        br_resolve;
  logic        br_new;
  logic        req_valid;
  logic [31:0] req_pc;

  // Request arbitration: WB flush beats the pending target, which beats a new branch.
  always_comb begin
    br_resolve = (state_q == IDLE) & ex_valid & ex_is_bj & ~wb_flush;
    br_new     = br_resolve & ex_taken;
    req_valid  = wb_flush | (state_q == PEND) | br_new;
    if (wb_flush) begin
      req_pc = wb_target;
    end else if (state_q == PEND) begin
      req_pc = pend_pc_q;
    end else begin
      req_pc = ex_target;
    end
  end

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pend_pc_d   = pend_pc_q;
    cnt_br_d    = cnt_br_q + {{(CNT_W-1){1'b0}}, br_resolve};
    cnt_taken_d = cnt_taken_q + {{(CNT_W-1){1'b0}}, br_new};
    cnt_stall_d = cnt_stall_q;
    if (req_valid) begin
      if (if_ready) begin
        state_d = IDLE;
      end else begin
        state_d     = PEND;
        pend_pc_d   = req_pc;
        cnt_stall_d = cnt_stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_pc_q   <= '0;
      cnt_br_q    <= '0;
      cnt_taken_q <= '0;
      cnt_stall_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      cnt_br_q    <= cnt_br_d;
      cnt_taken_q <= cnt_taken_d;
      cnt_stall_q <= cnt_stall_d;
    end
  end

  // Reset masks every output, including the combinational request path.
  assign redir_valid = req_valid & ~reset;
  assign redir_pc    = redir_valid ? req_pc : 32'h0;
  assign flush_fd    = redir_valid;
  assign ex_kill     = ~reset & ((state_q == PEND) | wb_flush);
  assign cnt_br      = reset ? '0 : cnt_br_q;
  assign cnt_taken   = reset ? '0 : cnt_taken_q;
  assign cnt_stall   = reset ? '0 : cnt_stall_q;

`ifndef SYNTHESIS
  // A raised request may only retire through a handshake; its PC only changes on a flush.
  a_valid_hold : assert property (@(posedge clk) disable iff (reset)
    (redir_valid && !if_ready) |=> (reset || redir_valid));
  a_pc_stable : assert property (@(posedge clk) disable iff (reset)
    (redir_valid && !if_ready) |=> (reset || wb_flush || redir_pc == $past(redir_pc)));
`endif

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Scoreboard bench for br_redirect_ctrl: a cycle-level reference model queues expected
// outputs per cycle, an independent monitor pops and compares them.
module tb_br_redirect_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ex_valid = 1'b0, ex_is_bj = 1'b0, ex_taken = 1'b0;
  logic [31:0]      ex_target = '0;
  logic             wb_flush = 1'b0;
  logic [31:0]      wb_target = '0;
  logic             if_ready = 1'b0;
  logic             redir_valid, flush_fd, ex_kill;
  logic [31:0]      redir_pc;
  logic [CNT_W-1:0] cnt_br, cnt_taken, cnt_stall;

  br_redirect_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_is_bj(ex_is_bj), .ex_taken(ex_taken), .ex_target(ex_target),
    .wb_flush(wb_flush), .wb_target(wb_target), .if_ready(if_ready),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .flush_fd(flush_fd), .ex_kill(ex_kill),
    .cnt_br(cnt_br), .cnt_taken(cnt_taken), .cnt_stall(cnt_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] pc;
    logic        kill;
    logic [31:0] br, tk, st;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: a pending redirect is just "is there an unaccepted target".
  bit          m_pending = 1'b0;
  logic [31:0] m_pend_pc = '0;
  logic [31:0] m_br = '0, m_tk = '0, m_st = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and queue the expected outputs.
  task automatic cycle(input string tag, input bit rst, input bit ev, input bit bj, input bit tk,
                       input logic [31:0] et, input bit wf, input logic [31:0] wt, input bit ir);
    exp_t e;
    bit   want;
    logic [31:0] pc;
    @(negedge clk);
    reset = rst; ex_valid = ev; ex_is_bj = bj; ex_taken = tk; ex_target = et;
    wb_flush = wf; wb_target = wt; if_ready = ir;
    want = wf || m_pending || (ev && bj && tk);
    pc   = wf ? wt : (m_pending ? m_pend_pc : et);
    e.tag   = tag;
    e.valid = !rst && want;
    e.pc    = e.valid ? pc : 32'h0;
    e.kill  = !rst && (m_pending || wf);
    e.br    = rst ? 32'h0 : m_br;
    e.tk    = rst ? 32'h0 : m_tk;
    e.st    = rst ? 32'h0 : m_st;
    exp_q.push_back(e);
    if (rst) begin
      m_pending = 1'b0; m_pend_pc = '0; m_br = '0; m_tk = '0; m_st = '0;
    end else begin
      if (!m_pending && ev && bj && !wf) begin
        m_br = m_br + 1;
        if (tk) m_tk = m_tk + 1;
      end
      if (want && !ir) begin
        m_st = m_st + 1;
        m_pending = 1'b1;
        m_pend_pc = pc;
      end else if (want) begin
        m_pending = 1'b0;
      end
    end
  endtask

  task automatic idle_cycle(input string tag, input bit ir);
    cycle(tag, 0, 0, 0, 0, 32'h0, 0, 32'h0, ir);
  endtask

  // Monitor: samples between the falling and rising edge, once inputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".redir_valid"}, {31'h0, redir_valid}, {31'h0, e.valid});
        check({e.tag, ".redir_pc"},    redir_pc, e.pc);
        check({e.tag, ".flush_fd"},    {31'h0, flush_fd}, {31'h0, e.valid});
        check({e.tag, ".ex_kill"},     {31'h0, ex_kill}, {31'h0, e.kill});
        check({e.tag, ".cnt_br"},      cnt_br, e.br);
        check({e.tag, ".cnt_taken"},   cnt_taken, e.tk);
        check({e.tag, ".cnt_stall"},   cnt_stall, e.st);
      end
    end
  end

  initial begin
    int budget;
    cycle("reset0", 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    cycle("reset1", 1, 1, 1, 1, 32'h1C000004, 0, 32'h0, 1);

    // Taken branch, accepted at once; then a not-taken branch and a non-branch.
    cycle("beq_taken", 0, 1, 1, 1, 32'h1C000040, 0, 32'h0, 1);
    idle_cycle("after_beq", 1);
    cycle("bne_nt", 0, 1, 1, 0, 32'h1C000080, 0, 32'h0, 1);
    cycle("non_bj", 0, 1, 0, 1, 32'h1C000090, 0, 32'h0, 1);

    // Fetch stall: three refused cycles then acceptance; ex_* must be ignored while pending.
    cycle("stall0", 0, 1, 1, 1, 32'h1C000100, 0, 32'h0, 0);
    cycle("stall1", 0, 1, 1, 1, 32'h1C000AAA, 0, 32'h0, 0);
    cycle("stall2", 0, 1, 1, 0, 32'h1C000BBB, 0, 32'h0, 0);
    cycle("stall3", 0, 1, 1, 1, 32'h1C000CCC, 0, 32'h0, 1);
    idle_cycle("after_stall", 1);

    // Branch and flush together: flush wins, branch uncounted.
    cycle("simul", 0, 1, 1, 1, 32'h1C000200, 1, 32'h1C008000, 1);

    // Back-to-back taken branches with fetch always ready.
    cycle("b2b0", 0, 1, 1, 1, 32'h1C000500, 0, 32'h0, 1);
    cycle("b2b1", 0, 1, 1, 1, 32'h1C000600, 0, 32'h0, 1);

    // Flush overrides a pending target.
    cycle("pflush0", 0, 1, 1, 1, 32'h1C000300, 0, 32'h0, 0);
    cycle("pflush1", 0, 0, 0, 0, 32'h0, 1, 32'h1C008000, 0);
    idle_cycle("pflush2", 0);
    idle_cycle("pflush3", 1);
    // Flush in PEND with fetch ready discards the old target.
    cycle("pflush4", 0, 1, 1, 1, 32'h1C000310, 0, 32'h0, 0);
    cycle("pflush5", 0, 0, 0, 0, 32'h0, 1, 32'h1C00A000, 1);
    idle_cycle("pflush6", 1);

    // Reset while pending: no redirect afterwards.
    cycle("rpend0", 0, 1, 1, 1, 32'h1C000400, 0, 32'h0, 0);
    cycle("rpend1", 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    idle_cycle("rpend2", 0);
    idle_cycle("rpend3", 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle("rand",
            ($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 70),
            ($urandom_range(0, 99) < 50),
            $urandom_range(0, 1),
            $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 99) < 10),
            $urandom,
            ($urandom_range(0, 99) < 55));
    end
    idle_cycle("drain", 1);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #5;
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/br_redirect_ctrl.md
# br_redirect_ctrl

Sequences control-flow redirects for the five-stage LoongArch pipeline. It consumes the EX-stage branch resolution (taken/not-taken plus target) and the WB-stage exception/ertn flush. It arbitrates the two into a single redirect request to the fetch stage and holds that request until fetch accepts it. It also generates the wrong-path kill signals for IF/ID and EX, and keeps branch performance counters.

## Interface
- CNT_W, 32, width of each performance counter (wraps modulo 2^CNT_W)

- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- ex_valid  in  1  EX holds a valid instruction that advances this cycle
- ex_is_bj  in  1  EX instruction is of branch/jump type
- ex_taken  in  1  branch resolver result for the EX instruction (1 for JIRL/B/BL)
- ex_target  in  32  resolved target PC
- wb_flush  in  1  exception/ertn flush from WB
- wb_target  in  32  flush target PC (entry or era)
- if_ready  in  1  fetch accepts a redirect this cycle
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  32  redirect PC, passed unmodified (no alignment check; fetch raises ADEF)
- flush_fd  out  1  kill the instructions in IF and ID (wrong path)
- ex_kill  out  1  treat the EX input as a bubble this cycle
- cnt_br  out  CNT_W  resolved branches
- cnt_taken  out  CNT_W  taken branches
- cnt_stall  out  CNT_W  cycles a redirect waited on fetch

## Operation
- States: IDLE and PEND. PEND holds pend_pc (32-bit register).
- Request sources, priority highest first:
  - wb_flush: any state.
  - PEND: pend_pc.
  - New taken branch: IDLE, ex_valid & ex_is_bj & ex_taken.
- Redirect output:
  - redir_valid = 1 whenever any source is active; redir_pc comes from the winning source.
  - The new-branch and wb_flush paths are combinational: the request is visible in the same cycle.
- State transitions:
  - If redir_valid & if_ready: the request completes and the next state is IDLE.
  - If redir_valid & !if_ready: the next state is PEND, and pend_pc latches redir_pc.
- wb_flush while in PEND overrides the pending target.
  - With if_ready=0, pend_pc is overwritten with wb_target.
  - With if_ready=1, the next state is IDLE and the old target is discarded.
- flush_fd = redir_valid.
- ex_kill = (state==PEND) | wb_flush. In PEND the ex_* inputs are ignored, because wrong-path instructions cannot resolve branches.
- Counters (registered, visible the next cycle):
  - cnt_br += 1 when in IDLE with ex_valid & ex_is_bj & !wb_flush.
  - cnt_taken += 1 under the same condition when ex_taken is also 1.
  - cnt_stall += 1 on each cycle with redir_valid & !if_ready.
  - All counters wrap silently.
- A branch in EX in the same cycle as wb_flush is killed: it is not counted and does not redirect.

## Timing
- Reset behaviour:
  - While reset=1, all outputs are forced to 0, including the combinational ones.
  - On the next edge: state=IDLE, pend_pc=0, all counters=0.
  - Reset during PEND discards the pending redirect; there is no redirect after reset deasserts.
- Latency:
  - Taken branch to redir_valid: 0 cycles.
  - With if_ready=1 the redirect lasts exactly 1 cycle.
  - With if_ready=0 for N cycles, redir_valid stays high for N+1 cycles and redir_pc is stable throughout.
- Handshake: a transfer occurs only on a cycle with redir_valid & if_ready. Once redir_valid is raised, it never drops before that cycle, except on reset.
- Back-to-back: a new taken branch can be accepted in the cycle after completion (state is IDLE). The throughput is 1 redirect per cycle when if_ready is held at 1.
- Not-taken branches and non-BJ instructions produce no output change except for the counters.

## Test plan
- Taken BEQ:
  - Stimulus: ex_valid=1, ex_is_bj=1, ex_taken=1, ex_target=0x1C000040, if_ready=1.
  - Same cycle: redir_valid=1, redir_pc=0x1C000040, flush_fd=1.
  - Next cycle: all outputs 0, cnt_br=1, cnt_taken=1.
- Not-taken BNE (ex_taken=0):
  - redir_valid, flush_fd and ex_kill stay 0.
  - cnt_br increments by 1; cnt_taken is unchanged.
- Fetch stall:
  - Stimulus: taken branch to 0x1C000100, if_ready=0 for 3 cycles then 1.
  - redir_valid=1 for 4 cycles with redir_pc constant 0x1C000100.
  - ex_kill=1 for the 3 PEND cycles.
  - cnt_stall=3, then IDLE.
- Simultaneous events:
  - Stimulus: taken branch (target 0x1C000200) and wb_flush (wb_target=0x1C008000) in the same cycle, if_ready=1.
  - redir_pc=0x1C008000, ex_kill=1, cnt_br and cnt_taken unchanged.
- wb_flush in PEND:
  - Stimulus: pending target 0x1C000300 with if_ready=0, then wb_flush to 0x1C008000 with if_ready still 0.
  - From that cycle on, redir_pc=0x1C008000 until accepted.
- Reset mid-PEND:
  - Stimulus: reset=1 for 1 cycle while pending.
  - During reset all outputs are 0.
  - After the edge: IDLE, counters 0, no redirect reissued when reset=0.
